disp_scan_decoder: RTL and testbench
====================================

DISP_SCAN_DECODER -- requirements
Module: disp_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical synchronized samples required before a scan slot is captured.
REQ-002 Parameter FRAME_TIMEOUT, default 2000000: clocks without a completed frame before stale asserts.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset; this block has exactly one clock, clk, and this one reset.
REQ-005 anodes  in  4  multiplexed digit enables, active-low, bit i = digit i.
REQ-006 cathodes  in  7  segment pattern, active-low, bit6..bit0 = g..a.
REQ-007 digit_seg  out  28  captured patterns, digit i at [7i+6:7i], active-low.
REQ-008 digit_blank  out  4  bit i high = digit i not driven during the last frame.
REQ-009 frame_valid  out  1  one-clock pulse per completed frame.
REQ-010 mode  out  2  00 LOC, 01 UnLC, 10 PAUS, 11 unrecognised.
REQ-011 mode_valid  out  1  high when mode reflects a non-stale frame.
REQ-012 stale  out  1  high when no frame has completed within FRAME_TIMEOUT clocks.
REQ-013 err_multi  out  1  one-clock pulse when a stable sample has more than one anode low.
REQ-014 frame_count  out  8  completed-frame counter, wraps 255->0.

Function
REQ-015 anodes and cathodes SHALL pass through a two-flop synchronizer before any use.
REQ-016 A stability counter SHALL reset to 0 on any change of the synchronized 11-bit {anodes,cathodes} and increment otherwise, saturating at STABLE_CYCLES-1.
REQ-017 A sample SHALL be "stable" on the clock its counter reaches STABLE_CYCLES-1; each stable event SHALL be acted on exactly once, until the next change.
REQ-018 Stable sample with exactly one anode low (digit i): store cathodes into slot i and set seen[i].
REQ-019 Stable sample with anodes 1111: no capture, no error.
REQ-020 Stable sample with two or more anodes low: no capture; err_multi pulses on the following clock.
REQ-021 A frame SHALL complete on capture of digit 3 when seen[1] and seen[2] are set; otherwise the digit-3 capture is stored and no frame completes.
REQ-022 On frame completion, the next clock SHALL: copy slots to digit_seg, set digit_blank[i] = ~seen[i] (digit 3 counted as seen), pulse frame_valid, increment frame_count, update mode, clear seen[2:0], and restart the timeout counter.
REQ-023 Mode decode (d3,d2,d1,d0 active-low): LOC = 1000111, 1000000, 1000110, blank; UnLC = 1000001, 0101011, 1000111, 1000110; PAUS = 0001100, 0001000, 1000001, 0010010; any other combination = 11.
REQ-024 The timeout counter SHALL increment every clock not completing a frame and saturate; stale SHALL assert when it reaches FRAME_TIMEOUT and clear on the frame_valid clock.
REQ-025 mode_valid SHALL equal (at least one frame since reset) AND NOT stale.
REQ-026 A repeated capture of a digit within one frame SHALL overwrite its slot (last value wins).

Reset
REQ-027 While rst_n is low, the following SHALL be held: digit_seg all 1s, digit_blank 1111, frame_valid 0, mode 11, mode_valid 0, stale 0, err_multi 0, frame_count 0.
REQ-028 While rst_n is low, the synchronizers, stability counter, slots, seen flags and timeout counter SHALL be cleared; synchronizers reset to anodes 1111 and cathodes all 1s.
REQ-029 Assertion of rst_n mid-frame SHALL discard partial captures; the first frame after release requires fresh captures of digits 1, 2 and 3.

Structure
REQ-030 Shared package lock_disp_pkg SHALL hold the mode encodings and the 7-bit glyph constants for C, O, L, U, n, S, A and P; the display-driving side uses the same package.
REQ-031 Synchronizer plus stability counter SHALL be one sub-module, disp_stable_filter, parameterized by width and STABLE_CYCLES.

Verification
REQ-032 LOC scan (blank, 1000110, 1000000, 1000111), 40 clocks per slot -> frame_valid after the digit-3 capture, mode 00, digit_blank 0001, frame_count 1.
REQ-033 UnLC scan then PAUS scan -> mode 01 after the first frame and mode 10 after the second; digit_seg matches the glyphs; digit_blank 0000.
REQ-034 Pattern toggling every 10 clocks (below STABLE_CYCLES) -> no capture, no frame_valid; after FRAME_TIMEOUT clocks -> stale 1, mode_valid 0.
REQ-035 anodes 1100 held for 40 clocks -> single err_multi pulse, slots unchanged.
REQ-036 rst_n low after digits 1 and 2 are captured, then released and digit 3 alone presented -> no frame_valid; a full scan then gives frame_count 1.
REQ-037 256 LOC frames -> frame_count wraps to 0; mode_valid stays 1.

Source files
------------

// File: rtl/lock_disp_pkg.sv
// Shared definitions for the lock display: 7-segment glyphs (active-low, g..a)
// and the mode encodings recovered from a scanned frame.
package lock_disp_pkg;

    typedef enum logic [1:0] {
        MODE_LOC  = 2'b00,
        MODE_UNLC = 2'b01,
        MODE_PAUS = 2'b10,
        MODE_UNK  = 2'b11
    } disp_mode_e;

    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_O = 7'b1000000;
    localparam logic [6:0] GLYPH_L = 7'b1000111;
    localparam logic [6:0] GLYPH_U = 7'b1000001;
    localparam logic [6:0] GLYPH_N = 7'b0101011;
    localparam logic [6:0] GLYPH_S = 7'b0010010;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_P = 7'b0001100;

    // d0 content is ignored for LOC; only its blank state matters
    function automatic disp_mode_e decode_mode(input logic [6:0] d3, input logic [6:0] d2,
                                               input logic [6:0] d1, input logic [6:0] d0,
                                               input logic blank0);
        if (d3 == GLYPH_L && d2 == GLYPH_O && d1 == GLYPH_C && blank0)
            return MODE_LOC;
        if (d3 == GLYPH_U && d2 == GLYPH_N && d1 == GLYPH_L && d0 == GLYPH_C && !blank0)
            return MODE_UNLC;
        if (d3 == GLYPH_P && d2 == GLYPH_A && d1 == GLYPH_U && d0 == GLYPH_S && !blank0)
            return MODE_PAUS;
        return MODE_UNK;
    endfunction

endpackage

// File: rtl/disp_stable_filter.sv
// Two-flop synchronizer plus stability counter; o_fire pulses once per settled value,
// on the clock the counter holds STABLE_CYCLES-1, with o_data carrying that value.
module disp_stable_filter #(
    parameter int               WIDTH         = 11,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RST_VAL       = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_fire
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [CW-1:0]    r_cnt;
    logic             r_fire;
    logic             w_change;
    logic [CW-1:0]    w_cnt_next;

    assign w_change = (r_meta != r_sync);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_change)
            w_cnt_next = '0;
        else if (r_cnt != CNT_MAX)
            w_cnt_next = r_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_cnt  <= '0;
            r_fire <= 1'b0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
            r_cnt  <= w_cnt_next;
            // fire only on the transition into saturation, never while parked there
            r_fire <= (w_cnt_next == CNT_MAX) && (w_change || r_cnt != CNT_MAX);
        end
    end

    assign o_data = r_sync;
    assign o_fire = r_fire;

endmodule

// File: rtl/disp_scan_decoder.sv
// Recovers digit patterns from a multiplexed 4-digit 7-segment scan, assembles frames
// on the digit-3 capture and decodes the lock mode shown on the display.
module disp_scan_decoder
    import lock_disp_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anodes,
    input  logic [6:0]  cathodes,
    output logic [27:0] digit_seg,
    output logic [3:0]  digit_blank,
    output logic        frame_valid,
    output logic [1:0]  mode,
    output logic        mode_valid,
    output logic        stale,
    output logic        err_multi,
    output logic [7:0]  frame_count
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(FRAME_TIMEOUT);

    logic [10:0]     w_smp;
    logic            w_fire;
    logic [3:0]      w_an;
    logic [6:0]      w_ca;
    logic [2:0]      w_nlow;
    logic [1:0]      w_idx;

    logic [3:0][6:0] r_slot;
    logic [2:0]      r_seen;
    logic            r_done;
    logic            r_any;
    logic [TW-1:0]   r_tmo;

    disp_stable_filter #(
        .WIDTH         (11),
        .STABLE_CYCLES (STABLE_CYCLES),
        .RST_VAL       (11'h7FF)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({anodes, cathodes}),
        .o_data (w_smp),
        .o_fire (w_fire)
    );

    assign w_an = w_smp[10:7];
    assign w_ca = w_smp[6:0];

    always_comb begin
        w_nlow = '0;
        w_idx  = '0;
        for (int i = 0; i < 4; i++) begin
            if (!w_an[i]) begin
                w_nlow = w_nlow + 3'd1;
                w_idx  = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot      <= '1;
            r_seen      <= '0;
            r_done      <= 1'b0;
            r_any       <= 1'b0;
            r_tmo       <= '0;
            digit_seg   <= '1;
            digit_blank <= 4'hF;
            frame_valid <= 1'b0;
            mode        <= MODE_UNK;
            err_multi   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            r_done      <= 1'b0;

            if (r_done) begin
                digit_seg   <= r_slot;
                digit_blank <= {1'b0, ~r_seen};
                frame_valid <= 1'b1;
                frame_count <= frame_count + 8'd1;
                mode        <= decode_mode(r_slot[3], r_slot[2], r_slot[1], r_slot[0], ~r_seen[0]);
                r_seen      <= '0;
                r_tmo       <= '0;
                r_any       <= 1'b1;
            end else if (r_tmo != TMO_MAX) begin
                r_tmo <= r_tmo + TW'(1);
            end

            // placed after the frame-completion clear so a same-clock capture still sticks
            if (w_fire) begin
                if (w_nlow == 3'd1) begin
                    r_slot[w_idx] <= w_ca;
                    case (w_idx)
                        2'd0:    r_seen[0] <= 1'b1;
                        2'd1:    r_seen[1] <= 1'b1;
                        2'd2:    r_seen[2] <= 1'b1;
                        default: r_done    <= r_seen[1] & r_seen[2];
                    endcase
                end else if (w_nlow > 3'd1) begin
                    err_multi <= 1'b1;
                end
            end
        end
    end

    assign stale      = (r_tmo == TMO_MAX);
    assign mode_valid = r_any & ~stale;

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Scoreboard bench: expected frames are queued as scans are driven and checked on frame_valid.
module tb_disp_scan_decoder;

    localparam int SC  = 16;
    localparam int TMO = 500;

    localparam logic [6:0] G_C = 7'b1000110;
    localparam logic [6:0] G_O = 7'b1000000;
    localparam logic [6:0] G_L = 7'b1000111;
    localparam logic [6:0] G_U = 7'b1000001;
    localparam logic [6:0] G_N = 7'b0101011;
    localparam logic [6:0] G_S = 7'b0010010;
    localparam logic [6:0] G_A = 7'b0001000;
    localparam logic [6:0] G_P = 7'b0001100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anodes = 4'hF;
    logic [6:0]  cathodes = 7'h7F;
    logic [27:0] digit_seg;
    logic [3:0]  digit_blank;
    logic        frame_valid;
    logic [1:0]  mode;
    logic        mode_valid;
    logic        stale;
    logic        err_multi;
    logic [7:0]  frame_count;

    typedef struct {
        logic [27:0] seg;
        logic [3:0]  blank;
        logic [1:0]  mode;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    logic [27:0] mask_mon;
    logic [7:0]  exp_cnt = 8'd0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_err = 0;
    int          err_base;

    always #5 clk = ~clk;

    disp_scan_decoder #(.STABLE_CYCLES(SC), .FRAME_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anodes      (anodes),
        .cathodes    (cathodes),
        .digit_seg   (digit_seg),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .stale       (stale),
        .err_multi   (err_multi),
        .frame_count (frame_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] ca, input int n);
        anodes   = an;
        cathodes = ca;
        tick(n);
    endtask

    task automatic scan(input logic [6:0] d3, input logic [6:0] d2, input logic [6:0] d1,
                        input logic [6:0] d0, input logic b0);
        if (b0) show(4'hF, 7'h7F, 40);
        else    show(4'b1110, d0, 40);
        show(4'b1101, d1, 40);
        show(4'b1011, d2, 40);
        show(4'b0111, d3, 40);
    endtask

    task automatic expect_frame(input logic [27:0] seg, input logic [3:0] blank, input logic [1:0] md);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.seg   = seg;
        e.blank = blank;
        e.mode  = md;
        e.cnt   = exp_cnt;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && q.size() != 0; i++) tick(1);
        check_val(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset();
        check_val("rst_seg", 32'(digit_seg), 32'h0FFFFFFF);
        check_val("rst_blank", 32'(digit_blank), 32'hF);
        check_val("rst_fv", 32'(frame_valid), 32'd0);
        check_val("rst_mode", 32'(mode), 32'd3);
        check_val("rst_mv", 32'(mode_valid), 32'd0);
        check_val("rst_stale", 32'(stale), 32'd0);
        check_val("rst_err", 32'(err_multi), 32'd0);
        check_val("rst_cnt", 32'(frame_count), 32'd0);
    endtask

    task automatic do_reset();
        anodes   = 4'hF;
        cathodes = 7'h7F;
        rst_n    = 1'b0;
        tick(5);
        check_reset();
        exp_cnt = 8'd0;
        rst_n   = 1'b1;
        tick(2);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_multi) n_err++;
            if (frame_valid) begin
                if (q.size() == 0) begin
                    check_val("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e_mon    = q.pop_front();
                    mask_mon = '1;
                    for (int i = 0; i < 4; i++)
                        if (e_mon.blank[i]) mask_mon[7*i +: 7] = 7'h00;
                    check_val("frame_seg", 32'(digit_seg & mask_mon), 32'(e_mon.seg & mask_mon));
                    check_val("frame_blank", 32'(digit_blank), 32'(e_mon.blank));
                    check_val("frame_mode", 32'(mode), 32'(e_mon.mode));
                    check_val("frame_cnt", 32'(frame_count), 32'(e_mon.cnt));
                    check_val("frame_mv", 32'(mode_valid), 32'd1);
                    check_val("frame_stale", 32'(stale), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(3);
        do_reset();

        // LOC with digit 0 blank
        expect_frame({G_L, G_O, G_C, 7'h7F}, 4'b0001, 2'b00);
        scan(G_L, G_O, G_C, 7'h7F, 1'b1);
        drain("loc_frame");

        expect_frame({G_U, G_N, G_L, G_C}, 4'b0000, 2'b01);
        scan(G_U, G_N, G_L, G_C, 1'b0);
        drain("unlc_frame");

        expect_frame({G_P, G_A, G_U, G_S}, 4'b0000, 2'b10);
        scan(G_P, G_A, G_U, G_S, 1'b0);
        drain("paus_frame");

        // digit 1 recaptured (last wins) and a multi-anode sample before digit 3
        err_base = n_err;
        expect_frame({G_L, G_O, G_C, 7'h7F}, 4'b0001, 2'b00);
        show(4'hF, 7'h7F, 40);
        show(4'b1101, G_O, 40);
        show(4'b1101, G_C, 40);
        show(4'b1011, G_O, 40);
        show(4'b1100, 7'h00, 40);
        show(4'b0111, G_L, 40);
        drain("overwrite_frame");
        check_val("err_pulses", 32'(n_err - err_base), 32'd1);

        // unsettled scan: never captures, timeout runs out
        check_val("stale_before", 32'(stale), 32'd0);
        for (int i = 0; i < 30; i++) begin
            show(4'b1101, G_C, 10);
            show(4'b0111, G_L, 10);
        end
        check_val("toggle_stale", 32'(stale), 32'd1);
        check_val("toggle_mv", 32'(mode_valid), 32'd0);
        check_val("toggle_cnt", 32'(frame_count), 32'(exp_cnt));

        // reset mid-frame discards digits 1 and 2
        show(4'hF, 7'h7F, 40);
        show(4'b1101, G_C, 40);
        show(4'b1011, G_O, 40);
        do_reset();
        show(4'b0111, G_L, 40);
        show(4'hF, 7'h7F, 40);
        check_val("rst_partial_cnt", 32'(frame_count), 32'd0);
        expect_frame({G_L, G_O, G_C, 7'h7F}, 4'b0001, 2'b00);
        scan(G_L, G_O, G_C, 7'h7F, 1'b1);
        drain("post_rst_frame");

        // 256 frames from reset wraps the counter to zero
        do_reset();
        for (int f = 0; f < 256; f++) begin
            expect_frame({G_L, G_O, G_C, 7'h7F}, 4'b0001, 2'b00);
            scan(G_L, G_O, G_C, 7'h7F, 1'b1);
        end
        drain("wrap_frames");
        check_val("wrap_cnt", 32'(frame_count), 32'd0);
        check_val("wrap_mv", 32'(mode_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
